// File: rtl/dot_acc_ctrl_pkg.sv
// Shared state encoding and sizing helpers for the dot-product sequencer.
package dot_acc_ctrl_pkg;

    localparam int N_DEFAULT     = 8;
    localparam int LEN_W_DEFAULT = 8;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WAIT_IN  = 3'd1,
        ISSUE    = 3'd2,
        WAIT_ACK = 3'd3,
        DONE     = 3'd4
    } state_t;

    // Room for 2^len_w-1 full-scale products without overflow.
    function automatic int acc_width(input int n, input int len_w);
        return 2 * n + len_w;
    endfunction

    function automatic int default_tmo(input int n);
        return 2 * n + 4;
    endfunction

endpackage

// File: rtl/dot_acc_ctrl_ack_watchdog.sv
// Counts cycles spent waiting for a multiplier ack and flags a hung multiplier.
module ack_watchdog
    import dot_acc_ctrl_pkg::*;
#(
    parameter int TMO = default_tmo(N_DEFAULT)
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic armed,
    input  logic ack,
    output logic fire
);

    localparam int             CW   = $clog2(TMO + 1);
    localparam logic [CW-1:0]  LAST = CW'(TMO - 2);

    logic [CW-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (armed && !ack) begin
            count <= count + 1'b1;
        end
    end

    // The value about to be reached is TMO-1, so the abort lands TMO cycles after the request.
    assign fire = armed && !ack && (count == LAST);

endmodule

// File: rtl/dot_acc_ctrl.sv
// Feeds operand pairs to the shift-add multiplier and accumulates the products into a dot product.
module dot_acc_ctrl
    import dot_acc_ctrl_pkg::*;
#(
    parameter  int N     = N_DEFAULT,
    parameter  int LEN_W = LEN_W_DEFAULT,
    parameter  int TMO   = default_tmo(N),
    localparam int ACC_W = acc_width(N, LEN_W)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic             in_valid,
    input  logic [N-1:0]     in_a,
    input  logic [N-1:0]     in_b,
    output logic             in_ready,
    output logic             mul_req,
    output logic [N-1:0]     mul_sn,
    output logic [N-1:0]     mul_sbn,
    input  logic [2*N-1:0]   mul_tich,
    input  logic             mul_ack,
    output logic             out_valid,
    output logic [ACC_W-1:0] out_sum,
    output logic             out_err,
    input  logic             out_ready,
    output logic             busy
);

    state_t           state;
    state_t           next_state;
    logic [ACC_W-1:0] acc;
    logic [LEN_W-1:0] remaining;
    logic [N-1:0]     op_a;
    logic [N-1:0]     op_b;
    logic             err;
    logic             wd_fire;

    ack_watchdog #(.TMO(TMO)) u_watchdog (
        .clk   (clk),
        .rst   (rst),
        .clear (state == ISSUE),
        .armed (state == WAIT_ACK),
        .ack   (mul_ack),
        .fire  (wd_fire)
    );

    always_comb begin
        next_state = state;
        case (state)
            IDLE:     if (start) next_state = (len == '0) ? DONE : WAIT_IN;
            WAIT_IN:  if (in_valid) next_state = ISSUE;
            ISSUE:    next_state = WAIT_ACK;
            WAIT_ACK: begin
                if (mul_ack) begin
                    next_state = (remaining == LEN_W'(1)) ? DONE : WAIT_IN;
                end else if (wd_fire) begin
                    next_state = DONE;
                end
            end
            DONE:     if (out_ready) next_state = IDLE;
            default:  next_state = IDLE;
        endcase
    end

    // Output flags are registered from the next state so they line up exactly with the state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            acc       <= '0;
            remaining <= '0;
            op_a      <= '0;
            op_b      <= '0;
            err       <= 1'b0;
            in_ready  <= 1'b0;
            mul_req   <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= next_state;
            in_ready  <= (next_state == WAIT_IN);
            mul_req   <= (next_state == ISSUE);
            out_valid <= (next_state == DONE);
            busy      <= (next_state != IDLE);
            case (state)
                IDLE: begin
                    if (start) begin
                        acc       <= '0;
                        err       <= 1'b0;
                        remaining <= len;
                    end
                end
                WAIT_IN: begin
                    if (in_valid) begin
                        op_a <= in_a;
                        op_b <= in_b;
                    end
                end
                WAIT_ACK: begin
                    if (mul_ack) begin
                        acc       <= acc + ACC_W'(mul_tich);
                        remaining <= remaining - 1'b1;
                    end else if (wd_fire) begin
                        err <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign mul_sn  = op_a;
    assign mul_sbn = op_b;
    assign out_sum = acc;
    assign out_err = err;

endmodule
